// File: rtl/multi_pattern_detector.sv
// multi_pattern_detector
//   Serial bit-stream detector with N independently programmable pattern
//   slots. Each slot holds a pattern of up to K bits and its own length.
//   Overlapping matches are detected, and each slot gives a one-cycle match pulse.
//
//   Optional feature macro: MATCH_COUNT_EN adds per-slot saturating match
//   counters with a registered read port (cnt_sel/cnt_data/cnt_clr).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   cfg_valid    config write request
//   cfg_ready    block can accept a config write
//   cfg_slot     target slot; writes to slots >= N are accepted and dropped
//   cfg_pattern  pattern; bit 0 = most recent stream bit
//   cfg_len      pattern length in bits (values > K are stored as K)
//   cfg_enable   slot enable
//   in_valid     stream bit qualifier
//   in           stream bit
//   cnt_sel      counter select               (MATCH_COUNT_EN only)
//   cnt_data     selected counter, 1-cycle lat (MATCH_COUNT_EN only)
//   cnt_clr      clear all counters           (MATCH_COUNT_EN only)
//   match        per-slot match pulse
//   match_any    OR of match
module multi_pattern_detector #(
  parameter int K     = 8,
  parameter int N     = 4,
  parameter int CNT_W = 16,
  localparam int SW   = (N > 1) ? $clog2(N) : 1,
  localparam int LW   = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SW-1:0]    cfg_slot,
  input  logic [K-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_enable,
  input  logic             in_valid,
  input  logic             in,
`ifdef MATCH_COUNT_EN
  input  logic [SW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_clr,
`endif
  output logic [N-1:0]     match,
  output logic             match_any
);

  // ST_RST holds cfg_ready low for the first cycle after reset release.
  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_BUSY} cfg_state_e;

  cfg_state_e      state_q, state_d;
  logic            cfg_acc;
  logic [K-1:0]    hist_q, hist_d;
  logic [LW-1:0]   fill_q, fill_d;
  logic [K-1:0]    pat_q [N];
  logic [LW-1:0]   len_q [N];
  logic [N-1:0]    en_q;
  logic [N-1:0]    match_q, match_d;
  logic [K-1:0]    mask;
  logic [LW-1:0]   len_clamped;

  assign len_clamped = (32'(cfg_len) > 32'(K)) ? LW'(K) : cfg_len;

  // Config handshake FSM
  always_comb begin
    state_d = state_q;
    cfg_acc = 1'b0;
    case (state_q)
      ST_RST:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (cfg_valid) begin
          cfg_acc = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: state_d = ST_IDLE;
      default: state_d = ST_RST;
    endcase
  end

  assign cfg_ready = (state_q == ST_IDLE);

  // Stream history and match evaluation on the post-shift history. Slot
  // config used here is the registered (old) one, so a same-cycle config
  // write only affects later bits.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = '0;
    mask    = '0;
    if (in_valid) begin
      hist_d = {hist_q[K-2:0], in};
      if (fill_q != LW'(K)) fill_d = fill_q + 1'b1;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < K; j++) mask[j] = (32'(len_q[i]) > 32'(j));
        match_d[i] = en_q[i] && (len_q[i] != '0) && (fill_d >= len_q[i]) &&
                     (((hist_d ^ pat_q[i]) & mask) == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      en_q    <= '0;
      for (int i = 0; i < N; i++) begin
        pat_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      // Slot numbers with no matching index fall through and are dropped.
      for (int i = 0; i < N; i++) begin
        if (cfg_acc && (32'(cfg_slot) == 32'(i))) begin
          pat_q[i] <= cfg_pattern;
          len_q[i] <= len_clamped;
          en_q[i]  <= cfg_enable;
        end
      end
    end
  end

  assign match     = match_q;
  assign match_any = |match_q;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_data_q;

  // Counters follow the registered match pulses; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      cnt_data_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_clr) cnt_q[i] <= '0;
        else if (match_q[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      cnt_data_q <= '0;
      for (int i = 0; i < N; i++) begin
        if (32'(cnt_sel) == 32'(i)) cnt_data_q <= cnt_q[i];
      end
    end
  end

  assign cnt_data = cnt_data_q;
`endif

endmodule

// File: tb/tb_multi_pattern_detector.sv
module tb_multi_pattern_detector;
  localparam int K  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_slot;
  logic [K-1:0]  cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_enable;
  logic          in_valid;
  logic          in;
  logic [N-1:0]  match;
  logic          match_any;
`ifdef MATCH_COUNT_EN
  logic [SW-1:0] cnt_sel;
  logic [15:0]   cnt_data;
  logic          cnt_clr;
  logic [1:0]    cnt_data2;
  logic          cfg_ready2;
  logic [N-1:0]  match2;
  logic          match_any2;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [K-1:0]  m_hist;
  int            m_fill;
  logic [K-1:0]  m_pat [N];
  int            m_len [N];
  bit            m_en  [N];
  bit            m_ready;
  logic [N-1:0]  exp_q [$];

  multi_pattern_detector #(.K(K), .N(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_slot(cfg_slot),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_enable(cfg_enable),
    .in_valid(in_valid), .in(in),
`ifdef MATCH_COUNT_EN
    .cnt_sel(cnt_sel), .cnt_data(cnt_data), .cnt_clr(cnt_clr),
`endif
    .match(match), .match_any(match_any)
  );

`ifdef MATCH_COUNT_EN
  multi_pattern_detector #(.K(K), .N(N), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_slot(cfg_slot),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_enable(cfg_enable),
    .in_valid(in_valid), .in(in),
    .cnt_sel(cnt_sel), .cnt_data(cnt_data2), .cnt_clr(cnt_clr),
    .match(match2), .match_any(match_any2)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic iv);
    rst = 1'b1; cfg_valid = 1'b0; in_valid = iv; in = 1'b1;
    @(posedge clk); #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_match_any", match_any, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in = 1'b0;
    chk("ready_low_after_release", cfg_ready, 0);
    @(posedge clk); #1;
    chk("ready_high_after_release", cfg_ready, 1);
    m_hist = '0; m_fill = 0; m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_pat[i] = '0; m_len[i] = 0; m_en[i] = 1'b0;
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  // One clock cycle: drive inputs, predict, then compare after the edge.
  task automatic tick(input logic cv, input int slot, input logic [K-1:0] pat,
                      input int len, input logic en, input logic iv, input logic b);
    logic [N-1:0] e;
    bit ok;
    bit acc;
    cfg_valid = cv; cfg_slot = slot[SW-1:0]; cfg_pattern = pat;
    cfg_len = len[LW-1:0]; cfg_enable = en; in_valid = iv; in = b;
    e = '0;
    if (iv) begin
      m_hist = {m_hist[K-2:0], b};
      if (m_fill < K) m_fill++;
      for (int i = 0; i < N; i++) begin
        if (m_en[i] && m_len[i] >= 1 && m_fill >= m_len[i]) begin
          ok = 1'b1;
          for (int j = 0; j < m_len[i]; j++)
            if (m_hist[j] != m_pat[i][j]) ok = 1'b0;
          e[i] = ok;
        end
      end
    end
    exp_q.push_back(e);
    acc = cv && m_ready;
    if (acc && slot < N) begin
      m_pat[slot] = pat;
      m_len[slot] = (len > K) ? K : len;
      m_en[slot]  = en;
    end
    m_ready = !acc;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("match", match, e);
    chk("match_any", match_any, |e);
    chk("cfg_ready", cfg_ready, m_ready);
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    tick(1'b0, 0, '0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    tick(1'b0, 0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int slot, input logic [K-1:0] pat, input int len, input logic en);
    tick(1'b1, slot, pat, len, en, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    logic rv, rb;
    clk = 1'b0; rst = 1'b1; cfg_valid = 1'b0; cfg_slot = '0; cfg_pattern = '0;
    cfg_len = '0; cfg_enable = 1'b0; in_valid = 1'b0; in = 1'b0;
`ifdef MATCH_COUNT_EN
    cnt_sel = '0; cnt_clr = 1'b0;
`endif

    // Reset release, then random stream with no slot enabled.
    do_reset(1'b0);
    for (int n = 0; n < 20; n++) begin
      rv = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      tick(1'b0, 0, '0, 0, 1'b0, rv, rb);
    end

    // Overlapping 101 on slot 0.
    do_reset(1'b0);
    cfg(0, 8'b101, 3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);

    // Fill guard: all-zero pattern of length 8.
    do_reset(1'b0);
    cfg(1, 8'h00, 8, 1'b1);
    for (int n = 0; n < 10; n++) bit_in(0);

    // Same-cycle config accept and stream bit.
    do_reset(1'b0);
    bit_in(1);
    tick(1'b1, 2, 8'b11, 2, 1'b1, 1'b1, 1'b1);
    bit_in(1);
    bit_in(0);

    // Gaps between bits of 101.
    do_reset(1'b0);
    cfg(0, 8'b101, 3, 1'b1);
    bit_in(1); idle(); idle(); bit_in(0); idle(); bit_in(1); idle(); idle();

    // Length above K clamps to K; disabled slot never matches.
    do_reset(1'b0);
    cfg(3, 8'hA5, 15, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    cfg(3, 8'hA5, 8, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(0); bit_in(1);

    // Reset during a pending BUSY cycle and with a matching bit in flight.
    cfg(0, 8'b1, 1, 1'b1);
    tick(1'b1, 1, 8'b1, 1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    bit_in(1); bit_in(1);

`ifdef MATCH_COUNT_EN
    do_reset(1'b0);
    cnt_sel = '0;
    cfg(0, 8'b1, 1, 1'b1);
    for (int n = 0; n < 5; n++) bit_in(1);
    idle(); idle();
    chk("cnt_five", cnt_data, 5);
    chk("cnt_saturate", cnt_data2, 3);
    cnt_sel = 2'd1;
    idle();
    chk("cnt_other_slot", cnt_data, 0);
    cnt_sel = '0;
    bit_in(1);
    cnt_clr = 1'b1;
    idle();
    cnt_clr = 1'b0;
    idle(); idle();
    chk("cnt_clear_wins", cnt_data, 0);
    chk("cnt_clear_sat", cnt_data2, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
